// File: rtl/uart_recv_pkg.sv
// Shared UART constants and receiver state encoding; the transmitter uses the
// same defaults so both ends agree on the bit period.
package uart_recv_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int UART_BPS_DEF = 9600;

  // Clocks per bit; valid range is 8..65535 so the 16-bit counter never overflows.
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_recv_if.sv
// Receive-side byte interface: the receiver drives it (master), the control
// logic consumes it (slave).
interface uart_recv_if;

  logic [7:0] uart_data;
  logic       uart_rx_done;
  logic       uart_frame_err;
  logic       uart_rx_busy;

  modport master (
    output uart_data,
    output uart_rx_done,
    output uart_frame_err,
    output uart_rx_busy
  );

  modport slave (
    input uart_data,
    input uart_rx_done,
    input uart_frame_err,
    input uart_rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a delay flop for falling-edge
// detection. Flops reset high to match the idle line.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  output logic rxd_sync,
  output logic rxd_fall
);

  // [0] metastability stage, [1] synchronised sample (d1), [2] delayed copy (d2)
  logic [2:0] sync_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], uart_rxd};
    end
  end

  assign rxd_sync = sync_reg[1];
  assign rxd_fall = sync_reg[2] & ~sync_reg[1];

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling of 8 data bits
// (LSB first) and the stop bit, one-cycle done / framing-error strobes.
module uart_recv
  import uart_recv_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int UART_BPS = UART_BPS_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  uart_recv_if.master rx_if
);

  localparam int          BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [15:0] MID_CNT = 16'(BPS_CNT / 2 - 1);
  localparam logic [15:0] END_CNT = 16'(BPS_CNT - 1);

  logic rxd_sync;
  logic rxd_fall;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .rxd_sync  (rxd_sync),
    .rxd_fall  (rxd_fall)
  );

  uart_state_t state_reg, state_next;
  logic [15:0] clk_cnt_reg, clk_cnt_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_reg, data_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic at_mid;
  logic at_end;
  logic sample_en;

  assign at_mid    = (clk_cnt_reg == MID_CNT);
  assign at_end    = (clk_cnt_reg == END_CNT);
  assign sample_en = (state_reg == ST_DATA) && at_mid && !bit_cnt_reg[3];

  // Each data bit lands directly in its final position, LSB first.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (sample_en && (bit_cnt_reg[2:0] == 3'(gi))) ? rxd_sync
                                                                           : shift_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = at_end ? 16'd0 : clk_cnt_reg + 16'd1;
    bit_cnt_next = bit_cnt_reg;
    data_next    = data_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Only a genuine high-to-low edge starts a frame; a stuck-low line never retriggers.
        if (rxd_fall) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (at_mid) begin
          if (!rxd_sync) begin
            state_next   = ST_DATA;
            bit_cnt_next = 4'd0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (sample_en) begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
        end
        if (at_end && (bit_cnt_reg == 4'd8)) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop gives half a bit of slack for back-to-back frames.
        if (at_mid) begin
          state_next = ST_IDLE;
          if (rxd_sync) begin
            data_next = shift_reg;
            done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if ((state_reg == ST_IDLE) || (state_next == ST_IDLE)) begin
      clk_cnt_next = 16'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= ST_IDLE;
      clk_cnt_reg <= 16'd0;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'h00;
      data_reg    <= 8'h00;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  assign rx_if.uart_data      = data_reg;
  assign rx_if.uart_rx_done   = done_reg;
  assign rx_if.uart_frame_err = err_reg;
  assign rx_if.uart_rx_busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: an ideal 8N1 line driver queues the
// expected outcome of each frame, and a per-cycle checker compares the strobes.
module tb_uart_recv;

  localparam int BPS = 16;
  localparam int LAT = 2 + 9 * BPS + BPS / 2;
  localparam int TOL = 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_rxd  = 1'b1;

  uart_recv_if rx_if ();

  uart_recv #(
    .CLK_FREQ (1600),
    .UART_BPS (100)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .rx_if     (rx_if.master)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] model_data = 8'h00;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         busy_run = 0;
  int         last_busy_len = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // Per-cycle checker against the queued frame outcomes.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        check("rst_data", rx_if.uart_data, 0);
        check("rst_done", rx_if.uart_rx_done, 0);
        check("rst_err", rx_if.uart_frame_err, 0);
        check("rst_busy", rx_if.uart_rx_busy, 0);
        model_data = 8'h00;
        exp_q.delete();
        busy_run = 0;
      end else begin
        check("strobe_exclusive", rx_if.uart_rx_done & rx_if.uart_frame_err, 0);
        if (rx_if.uart_rx_done || rx_if.uart_frame_err) begin
          check("busy_at_strobe", rx_if.uart_rx_busy, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {rx_if.uart_rx_done, rx_if.uart_frame_err}, 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind_err", rx_if.uart_frame_err, e.is_err);
            check_range("strobe_latency", cyc, e.exp_cyc - TOL, e.exp_cyc + TOL);
            if (!e.is_err) model_data = e.data;
          end
          if (rx_if.uart_rx_done) done_cnt++;
          if (rx_if.uart_frame_err) err_cnt++;
        end else if (exp_q.size() > 0 && cyc > exp_q[0].exp_cyc + TOL) begin
          check("strobe_missing_pending", exp_q.size(), 0);
          void'(exp_q.pop_front());
        end
        check("uart_data", rx_if.uart_data, model_data);
        if (rx_if.uart_rx_busy) begin
          busy_run++;
        end else if (busy_run > 0) begin
          last_busy_len = busy_run;
          busy_run = 0;
        end
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    @(posedge sys_clk);
    #1;
    uart_rxd = v;
    repeat (n - 1) @(posedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
    exp_t e;
    @(posedge sys_clk);
    #1;
    uart_rxd  = 1'b0;
    e.is_err  = !stop_bit;
    e.data    = b;
    e.exp_cyc = cyc + LAT;
    exp_q.push_back(e);
    repeat (period - 1) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], period);
    drive_bit(stop_bit, period);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || rx_if.uart_rx_busy) && k < 2000) begin
      @(posedge sys_clk);
      #1;
      k++;
    end
    check_range("idle_wait_cycles", k, 0, 1999);
    @(negedge sys_clk);
    #1;
  endtask

  initial begin
    logic [7:0] b96;
    b96 = 8'h96;

    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);

    // Single byte
    send_frame(8'h55, BPS, 1'b1);
    drive_bit(1'b1, 20);
    wait_idle();
    check("s1_data", rx_if.uart_data, 8'h55);
    check_range("s1_busy_len", last_busy_len, 151, 153);
    check("s1_done_cnt", done_cnt, 1);

    // Back-to-back frames, no idle gap
    send_frame(8'hA3, BPS, 1'b1);
    send_frame(8'h00, BPS, 1'b1);
    send_frame(8'hFF, BPS, 1'b1);
    drive_bit(1'b1, 20);
    wait_idle();
    check("s2_data", rx_if.uart_data, 8'hFF);
    check("s2_done_cnt", done_cnt, 4);
    check("s2_err_cnt", err_cnt, 0);

    // Short glitch is rejected at start-bit mid
    last_busy_len = 0;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check_range("s3_busy_len", last_busy_len, 1, 9);
    check("s3_busy", rx_if.uart_rx_busy, 0);
    check("s3_done_cnt", done_cnt, 4);

    // Framing error, then line stuck low for 50 bits
    send_frame(8'h3C, BPS, 1'b0);
    drive_bit(1'b0, 50 * BPS);
    drive_bit(1'b1, 2 * BPS);
    wait_idle();
    check("s4_data_kept", rx_if.uart_data, 8'hFF);
    check("s4_err_cnt", err_cnt, 1);
    check("s4_done_cnt", done_cnt, 4);

    // Reset during data bit 4 of 0x96
    drive_bit(1'b0, BPS);
    for (int i = 0; i < 4; i++) drive_bit(b96[i], BPS);
    drive_bit(b96[4], 4);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (2 * BPS) @(posedge sys_clk);
    check("s5_data_after_rst", rx_if.uart_data, 8'h00);
    check("s5_busy_after_rst", rx_if.uart_rx_busy, 0);
    send_frame(8'h5A, BPS, 1'b1);
    drive_bit(1'b1, 20);
    wait_idle();
    check("s5_data", rx_if.uart_data, 8'h5A);
    check("s5_done_cnt", done_cnt, 5);

    // Baud skew: bit periods of 15 and 17 cycles
    send_frame(8'hC3, 15, 1'b1);
    drive_bit(1'b1, 20);
    wait_idle();
    check("s6_data_fast", rx_if.uart_data, 8'hC3);
    send_frame(8'h00, BPS, 1'b1);
    drive_bit(1'b1, 20);
    wait_idle();
    send_frame(8'hC3, 17, 1'b1);
    drive_bit(1'b1, 20);
    wait_idle();
    check("s6_data_slow", rx_if.uart_data, 8'hC3);
    check("s6_done_cnt", done_cnt, 8);
    check("s6_err_cnt", err_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
UART receiver that pairs with the existing 8N1 UART transmitter. It takes the asynchronous serial line, synchronises it, and detects and validates the start bit. It samples 8 data bits (LSB first) and the stop bit at mid-bit, then presents each byte with a one-cycle done strobe. It sits at the serial front end, feeding received command/config bytes to the accelerator control logic.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 9600, baud rate
BPS_CNT (localparam), CLK_FREQ/UART_BPS, clocks per bit; must be ≥ 8 and ≤ 65535

Ports:
sys_clk  input  1  system clock, all logic on its rising edge
sys_rst_n  input  1  asynchronous active-low reset
uart_rxd  input  1  serial line, asynchronous, idle high
uart_data  output  8  last correctly framed byte; holds until the next good frame
uart_rx_done  output  1  one-cycle pulse, uart_data valid from this cycle onward
uart_frame_err  output  1  one-cycle pulse when the stop bit is sampled low
uart_rx_busy  output  1  high from start-bit detection until the frame ends or is aborted

Behaviour:
- Reset (async, sys_rst_n low): all synchroniser flops = 1; state = IDLE; clk_cnt = 0; bit_cnt = 0; shift register = 0; uart_data = 8'h00; uart_rx_done = 0; uart_frame_err = 0; uart_rx_busy = 0. Reset mid-frame discards the partial byte; no strobe is issued.
- Input path: 2-flop synchroniser plus a third delay flop. fall = d2 & ~d1 (previous high, current low). All sampling uses the synchronised d1.
- clk_cnt: 16 bits. Counts 0..BPS_CNT-1 while not IDLE, wraps to 0, and is forced to 0 in IDLE. mid = (clk_cnt == BPS_CNT/2 - 1). end = (clk_cnt == BPS_CNT-1).
- IDLE: on fall → START, busy = 1, clk_cnt = 0. No falling edge means no start, so a line held low never retriggers.
- START: at mid, if d1 = 0 → DATA with bit_cnt = 0. If d1 = 1 (glitch) → IDLE, busy = 0, no strobe.
- DATA: at each mid, shift d1 into bit position bit_cnt (LSB first) and increment bit_cnt. After the 8th sample (bit_cnt = 7), advance to STOP on the following end.
- STOP: at mid, sample d1.
  - If 1: uart_data <= shift register and uart_rx_done = 1 next cycle.
  - If 0: uart_frame_err = 1 next cycle and uart_data is unchanged.
  - Either way → IDLE, busy = 0 in the same cycle as the strobe.
  - Returning at mid-stop leaves half a bit of slack, so back-to-back frames are received.
- Strobes: uart_rx_done and uart_frame_err are mutually exclusive, each exactly one cycle.
- Latency: the strobe asserts 2 sync cycles + (9·BPS_CNT + BPS_CNT/2) cycles after the line's falling edge, ±1 cycle.
- Break / stuck-low after a framing error: stay in IDLE until the line goes high and then falls again.

Decomposition:
- Shared uart package: CLK_FREQ/UART_BPS defaults, the BPS_CNT derivation, and the state encoding (IDLE, START, DATA, STOP). The same constants serve the transmitter, so both ends agree on the bit period.
- One natural sub-module: uart_rx_sync (2-flop synchroniser + edge detect, reset to 1). Everything else stays in uart_recv.

Test Plan:
All scenarios run with CLK_FREQ=1600, UART_BPS=100 (BPS_CNT=16), driving the line with an ideal 8N1 model.
1. Single byte 0x55 → one uart_rx_done pulse, uart_data = 8'h55, frame_err never asserted, busy high ~152 cycles.
2. Back-to-back 0xA3, 0x00, 0xFF with no idle gap → three done pulses in order with correct data; no frame_err.
3. Line glitch low for 4 cycles, then high → busy pulses for ≤ 9 cycles, no done, no frame_err, state returns to IDLE.
4. 0x3C with stop bit forced low → single frame_err pulse, no done, uart_data keeps the previous value (0xFF from scenario 2). Holding the line low afterwards for 50 bits produces no further strobes.
5. Assert sys_rst_n low during data bit 4 of 0x96, release, then send 0x5A → no strobe for 0x96, all outputs at reset values during reset, next frame gives uart_data = 8'h5A.
6. Baud-skew check: send 0xC3 with bit period 15 and then 17 cycles → both received correctly with done pulses.
